// File: rtl/clk_edge_recover.sv
// clk_edge_recover: samples a divided clock as data in the clk domain.
// It emits one-cycle rise/fall enables, measures the rise-to-rise period
// and tracks lock on that period.
module clk_edge_recover #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned LOCK_COUNT  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_clk_in,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period,
  output logic             locked,
  output logic             lost
);

  // Two spare codes above LOCK_COUNT keep match+1 from wrapping after a
  // locked-to-measure fallback when LOCK_COUNT is 1.
  localparam int unsigned      MATCH_W     = $clog2(LOCK_COUNT + 2);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [MATCH_W-1:0] LOCK_TARGET = MATCH_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise_tick;
  logic                   r_fall_tick;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_period;
  logic [MATCH_W-1:0]     r_match;
  logic                   r_locked;
  logic                   r_lost;
  state_t                 r_state;

  logic                   w_s;
  logic                   w_rise;
  logic                   w_fall;
  logic [MATCH_W-1:0]     w_match_inc;
  logic                   w_lock_now;

  assign w_s         = r_sync[SYNC_STAGES-1];
  assign w_rise      = w_s & ~r_prev;
  assign w_fall      = ~w_s & r_prev;
  assign w_match_inc = r_match + MATCH_W'(1);
  assign w_lock_now  = (w_match_inc >= LOCK_TARGET);

  // Input synchronizer: shift div_clk_in in at bit 0, s is the top bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= SYNC_STAGES'({r_sync, div_clk_in});
    end
  end

  // Edge detect against the previous synchronized level; ticks are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev      <= 1'b0;
      r_rise_tick <= 1'b0;
      r_fall_tick <= 1'b0;
    end else begin
      r_prev      <= w_s;
      r_rise_tick <= w_rise;
      r_fall_tick <= w_fall;
    end
  end

  // Rise-to-rise period counter, restarting at 1 and saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_rise) begin
      r_cnt <= CNT_W'(1);
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Lock tracker; r_cnt on a rise is the measurement of the period just ended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_period <= '0;
      r_match  <= '0;
      r_locked <= 1'b0;
      r_lost   <= 1'b0;
    end else begin
      r_lost <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state  <= ST_MEASURE;
            r_period <= '0;
            r_match  <= '0;
          end
        end
        ST_MEASURE: begin
          if (w_rise) begin
            if (r_cnt == r_period) begin
              r_match <= w_match_inc;
              if (w_lock_now) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              r_period <= r_cnt;
              r_match  <= MATCH_W'(1);
              if (LOCK_COUNT <= 1) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
              end
            end
          end else if (r_cnt == CNT_MAX) begin
            r_state  <= ST_IDLE;
            r_period <= '0;
            r_match  <= '0;
          end
        end
        ST_LOCKED: begin
          if (w_rise) begin
            if (r_cnt != r_period) begin
              r_state  <= ST_MEASURE;
              r_period <= r_cnt;
              r_match  <= MATCH_W'(1);
              r_locked <= 1'b0;
              r_lost   <= 1'b1;
            end
          end else if (r_cnt == CNT_MAX) begin
            r_state  <= ST_IDLE;
            r_period <= '0;
            r_match  <= '0;
            r_locked <= 1'b0;
            r_lost   <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_period <= '0;
          r_match  <= '0;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign rise_tick = r_rise_tick;
  assign fall_tick = r_fall_tick;
  assign period    = r_period;
  assign locked    = r_locked;
  assign lost      = r_lost;

endmodule

// File: tb/tb_clk_edge_recover.sv
// Directed bench for clk_edge_recover: default instance, CNT_W=4 instance
// for the timeout path, LOCK_COUNT=1 instance for fast lock and async reset.
module tb_clk_edge_recover;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       din_a = 1'b0;
  logic       din_b = 1'b0;
  logic       din_c = 1'b0;

  logic       rise_a, fall_a, locked_a, lost_a;
  logic [7:0] period_a;
  logic       rise_b, fall_b, locked_b, lost_b;
  logic [3:0] period_b;
  logic       rise_c, fall_c, locked_c, lost_c;
  logic [7:0] period_c;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned cyc_n   = 0;

  typedef struct {
    logic       din;
    logic       rt;
    logic       ft;
    logic [7:0] per;
    logic       lk;
    logic       ls;
  } vec_t;

  vec_t tv [14];

  always #5 clk = ~clk;

  clk_edge_recover u_a (
    .clk(clk), .rst_n(rst_n), .div_clk_in(din_a),
    .rise_tick(rise_a), .fall_tick(fall_a), .period(period_a),
    .locked(locked_a), .lost(lost_a)
  );

  clk_edge_recover #(.CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .div_clk_in(din_b),
    .rise_tick(rise_b), .fall_tick(fall_b), .period(period_b),
    .locked(locked_b), .lost(lost_b)
  );

  clk_edge_recover #(.LOCK_COUNT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .div_clk_in(din_c),
    .rise_tick(rise_c), .fall_tick(fall_c), .period(period_c),
    .locked(locked_c), .lost(lost_c)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
  endtask

  // Advance one clk edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din_a = 1'b0;
    din_b = 1'b0;
    din_c = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int rises;
    int j;
    int lost_n;
    int last_rise;
    int lost_at;

    // Divide-by-2 input on the default instance, one row per clk edge.
    //         din   rt    ft    period lk    ls
    tv[0]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0};
    tv[4]  = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0};
    tv[8]  = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0};
    tv[10] = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0};
    tv[11] = '{1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0};
    tv[12] = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0};
    tv[13] = '{1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0};

    // Reset held while inputs toggle: every output stays 0.
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      din_a = ~din_a;
      din_b = ~din_b;
      din_c = ~din_c;
      cyc();
      chk("reset_hold",
          {rise_a, fall_a, period_a, locked_a, lost_a,
           rise_b, fall_b, period_b, locked_b, lost_b,
           rise_c, fall_c, period_c, locked_c, lost_c}, 32'd0);
    end
    din_a = 1'b0;
    din_b = 1'b0;
    din_c = 1'b0;
    cyc();
    rst_n = 1'b1;

    // Table: divide-by-2, first rise tick on the third edge counting the sampling edge.
    for (int i = 0; i < 14; i++) begin
      din_a = tv[i].din;
      cyc();
      chk($sformatf("div2_vec%0d", i),
          {20'd0, rise_a, fall_a, period_a, locked_a, lost_a},
          {20'd0, tv[i].rt, tv[i].ft, tv[i].per, tv[i].lk, tv[i].ls});
    end

    // 3 high / 3 low: period 6, lock on the 5th rise, no lost pulses.
    do_reset();
    rises  = 0;
    lost_n = 0;
    for (int p = 0; p < 8; p++) begin
      for (int k = 0; k < 6; k++) begin
        din_a = (k < 3);
        cyc();
        if (lost_a) lost_n++;
        if (rise_a) begin
          rises++;
          chk($sformatf("p6_lock_r%0d", rises), {31'd0, locked_a}, {31'd0, rises >= 5});
        end
      end
    end
    chk("p6_period", {24'd0, period_a}, 32'd6);
    chk("p6_no_lost", lost_n, 32'd0);

    // Switch to 4 high / 4 low while locked: one lost pulse, relock after 3 matches.
    j      = 0;
    lost_n = 0;
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < 8; k++) begin
        din_a = (k < 4);
        cyc();
        if (lost_a) lost_n++;
        if (rise_a) begin
          j++;
          chk($sformatf("p8_lock_r%0d", j), {31'd0, locked_a}, {31'd0, (j <= 1) || (j >= 5)});
          chk($sformatf("p8_period_r%0d", j), {24'd0, period_a}, (j <= 1) ? 32'd6 : 32'd8);
          chk($sformatf("p8_lost_r%0d", j), {31'd0, lost_a}, {31'd0, j == 2});
        end
      end
    end
    chk("p8_rises_seen", j, 32'd6);
    chk("p8_lost_once", lost_n, 32'd1);

    // CNT_W=4: lock at period 2, then hold low until the counter saturates.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      din_b = (i % 2 == 0);
      cyc();
    end
    chk("cw4_locked", {31'd0, locked_b}, 32'd1);
    chk("cw4_period", {28'd0, period_b}, 32'd2);
    din_b     = 1'b0;
    last_rise = -1;
    lost_at   = -1;
    for (int i = 0; i < 40 && lost_at < 0; i++) begin
      cyc();
      if (rise_b) last_rise = cyc_n;
      if (lost_b) begin
        lost_at = cyc_n;
        chk("to_locked", {31'd0, locked_b}, 32'd0);
        chk("to_period", {28'd0, period_b}, 32'd0);
      end
    end
    if (lost_at < 0) begin
      chk("to_lost_seen", 32'd0, 32'd1);
    end else begin
      chk("to_gap", lost_at - last_rise, 32'd15);
      cyc();
      chk("to_lost_1cyc", {30'd0, lost_b, locked_b}, 32'd0);
    end

    // Restart from IDLE: full 5-rise acquisition again.
    rises = 0;
    for (int i = 0; i < 16; i++) begin
      din_b = (i % 2 == 0);
      cyc();
      if (rise_b) begin
        rises++;
        chk($sformatf("reacq_r%0d", rises), {31'd0, locked_b}, {31'd0, rises >= 5});
      end
    end
    chk("reacq_rises", rises, 32'd7);

    // LOCK_COUNT=1: lock visible with the 2nd rise tick.
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      rises = 0;
      for (int i = 0; i < 10; i++) begin
        din_c = (i % 2 == 0);
        cyc();
        if (rise_c) begin
          rises++;
          chk($sformatf("lc1_p%0d_r%0d", pass, rises), {31'd0, locked_c}, {31'd0, rises >= 2});
          if (rises == 2) chk($sformatf("lc1_p%0d_per", pass), {24'd0, period_c}, 32'd2);
        end
      end
      chk($sformatf("lc1_p%0d_prelock", pass), {31'd0, locked_c}, 32'd1);
      if (pass == 0) begin
        // Mid-cycle reset clears outputs before any clk edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("lc1_async_rst", {20'd0, rise_c, fall_c, period_c, locked_c, lost_c}, 32'd0);
        din_c = 1'b0;
        cyc();
        rst_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
